stage3_writeback: RTL

Third and final pipeline stage of the three-stage RV32I core, directly downstream of the execute stage. It registers the execute-stage results, performs data-memory loads and stores over a valid/ready handshake, formats load data, and produces the register-file write port plus `wb_data`/`stage3_inst`, which feed back to the execute stage's forwarding muxes. It also stalls stages 1–2 while a memory access is outstanding and counts retired instructions.

---
 rtl/stage3_writeback_pkg.sv | 57 +++++
 rtl/stage3_writeback_load_extend.sv | 41 ++++
 rtl/stage3_writeback.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stage3_writeback_pkg.sv
// Shared RV32I definitions for the write-back stage: opcodes, funct3 codes,
// the bubble instruction, FSM state encodings and write-back source selection.
package stage3_writeback_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_LOAD = 2'd1,
        WB_LINK = 2'd2,
        WB_ALU  = 2'd3
    } wb_sel_e;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

    function automatic wb_sel_e wb_select(input logic [6:0] opcode);
        wb_sel_e sel;
        case (opcode)
            OPC_LOAD:                             sel = WB_LOAD;
            OPC_JAL, OPC_JALR:                    sel = WB_LINK;
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: sel = WB_ALU;
            OPC_STORE, OPC_BRANCH, OPC_SYSTEM:    sel = WB_NONE;
            default:                              sel = WB_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/stage3_writeback_load_extend.sv
// Load data formatter: picks the addressed byte/halfword lane out of the
// memory word and sign- or zero-extends it according to funct3.
module LoadExtend
    import stage3_writeback_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
    end

    // Halfword lane comes from addr[1] alone; misaligned addr[0] is ignored.
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'h00_0000, byte_sel};
            F3_LHU:  data_o = {16'h0000, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/stage3_writeback.sv
// Final RV32I pipeline stage: stage register, data-memory handshake, load/store
// formatting, register-file write port and retired-instruction counter.
module stage3_writeback
    import stage3_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] stage2_inst_in,
    input  logic [31:0] stage2_pc_in,
    input  logic [31:0] stage2_alu_in,
    input  logic [31:0] stage2_rs2_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] stage3_inst,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] instret
);

    // state    | meaning
    // IDLE     | stage holds a non-memory instruction or a bubble
    // ACCESS   | memory request outstanding, upstream frozen
    // COMPLETE | memory op finished, load data in ld_q, upstream moves again

    logic [31:0] inst_q, pc_q, alu_q, rs2_q;
    logic [31:0] ld_q, ld_d;
    logic [31:0] instret_q, instret_d;
    state_e      state_q, state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        in_access;
    wb_sel_e     wb_sel;
    logic [31:0] ld_fmt;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;

    assign opcode    = inst_q[6:0];
    assign funct3    = inst_q[14:12];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign in_access = (state_q == ST_ACCESS);
    assign wb_sel    = wb_select(opcode);

    LoadExtend u_load_extend (
        .word_i   (dmem_rdata),
        .addr_i   (alu_q[1:0]),
        .funct3_i (funct3),
        .data_o   (ld_fmt)
    );

    always_comb begin
        st_mask  = 4'b0000;
        st_wdata = rs2_q;
        case (funct3)
            F3_SB: begin
                st_mask  = 4'b0001 << alu_q[1:0];
                st_wdata = {4{rs2_q[7:0]}};
            end
            F3_SH: begin
                st_mask  = 4'b0011 << {alu_q[1], 1'b0};
                st_wdata = {2{rs2_q[15:0]}};
            end
            F3_SW: begin
                st_mask  = 4'hF;
                st_wdata = rs2_q;
            end
            default: begin
                st_mask  = 4'b0000;
                st_wdata = rs2_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q <= NOP_INST;
            pc_q   <= 32'h0;
            alu_q  <= 32'h0;
            rs2_q  <= 32'h0;
        end else if (!stall) begin
            inst_q <= stage2_inst_in;
            pc_q   <= stage2_pc_in;
            alu_q  <= stage2_alu_in;
            rs2_q  <= stage2_rs2_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture happens on every non-stalled edge, so IDLE and COMPLETE share
    // the same exit decision based on the instruction entering the stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_COMPLETE: begin
                state_d = is_mem_op(stage2_inst_in[6:0]) ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (dmem_ready) begin
                    state_d = ST_COMPLETE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = {alu_q[31:2], 2'b00};
        dmem_wdata  = st_wdata;
        dmem_wmask  = 4'b0000;
        stage3_inst = inst_q;
        wb_rd       = inst_q[11:7];
        wb_data     = 32'h0;
        wb_en       = 1'b0;
        instret     = instret_q;

        if (in_access) begin
            stall    = 1'b1;
            dmem_req = 1'b1;
            if (is_store) begin
                dmem_we    = 1'b1;
                dmem_wmask = st_mask;
            end
        end

        case (wb_sel)
            WB_LOAD: wb_data = ld_q;
            WB_LINK: wb_data = pc_q + 32'd4;
            WB_ALU:  wb_data = alu_q;
            default: wb_data = 32'h0;
        endcase

        wb_en = (wb_sel != WB_NONE) && (inst_q[11:7] != 5'd0) && !in_access;
    end

    always_comb begin
        ld_d = ld_q;
        if (in_access && dmem_ready && is_load) begin
            ld_d = ld_fmt;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (!stall && (inst_q != NOP_INST)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q      <= 32'h0;
            instret_q <= 32'h0;
        end else begin
            ld_q      <= ld_d;
            instret_q <= instret_d;
        end
    end

endmodule
